// File: rtl/demux_dispatch_if.sv
// ----------------------------------------------------------------------------
// demux_dispatch_if
//   Bundles the signals between the 1x8 demux dispatch controller and its
//   surroundings: the upstream valid/ready word input, the one-hot downstream
//   channel handshake, the demux select, and the status/counter outputs.
//
//   master : the environment (drives input words and channel readies)
//   slave  : the controller (accepts words, drives channel valids/select/status)
//
//   mode      1   0 = addressed (in_dest), 1 = round-robin
//   in_valid  1   input word valid
//   in_ready  1   controller can accept a word this cycle
//   in_data   DW  input word
//   in_dest   3   destination channel (addressed mode only)
//   out_valid 8   one-hot channel valid
//   out_data  DW  held word on the shared output bus
//   out_ready 8   per-channel ready
//   sel       3   targeted channel / demux select
//   drop      1   one-cycle pulse when a held word times out
//   busy      1   high while a word is held
//   sent_cnt  16  completed transfers, wrapping
//   drop_cnt  8   dropped words, saturating
// ----------------------------------------------------------------------------
interface demux_dispatch_if #(
    parameter int DW = 8
);
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2:0]    in_dest;
    logic [7:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [7:0]    out_ready;
    logic [2:0]    sel;
    logic          drop;
    logic          busy;
    logic [15:0]   sent_cnt;
    logic [7:0]    drop_cnt;

    modport master (
        output mode, in_valid, in_data, in_dest, out_ready,
        input  in_ready, out_valid, out_data, sel, drop, busy, sent_cnt, drop_cnt
    );

    modport slave (
        input  mode, in_valid, in_data, in_dest, out_ready,
        output in_ready, out_valid, out_data, sel, drop, busy, sent_cnt, drop_cnt
    );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// demux_dispatch_ctrl
//   Sequencing controller for a 1x8 demultiplexer. Takes one word at a time
//   from a valid/ready input, holds it on the shared output bus and raises the
//   valid of exactly one channel until that channel is ready. The channel is
//   either given with the word (addressed) or found by scanning the channels
//   from a round-robin pointer. A word that cannot be delivered within TIMEOUT
//   hold cycles is dropped. Counts sent and dropped words.
//
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    demux_dispatch_if.slave (handshakes, select, status, counters)
//
//   Parameters:
//     DW       data width
//     TIMEOUT  hold cycles without transfer before a drop; 0 disables dropping
// ----------------------------------------------------------------------------
module demux_dispatch_ctrl #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_dispatch_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // wait_cnt only has to reach TIMEOUT-1
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

    state_t          state;
    logic [2:0]      sel;
    logic [2:0]      rr_ptr;
    logic            mode_q;
    logic [WCW-1:0]  wait_cnt;
    logic [7:0]      out_valid;
    logic [DW-1:0]   out_data;
    logic            drop;
    logic [15:0]     sent_cnt;
    logic [7:0]      drop_cnt;

    logic            fire;
    logic            accept;
    logic            timeout_hit;
    logic [2:0]      rr_base;
    logic [2:0]      load_sel;
    logic [2:0]      scan_sel;

    // NOTE: every always_comb output gets a value on every path (here all are
    // assigned unconditionally), so no latch can be inferred.
    always_comb begin
        fire        = (state == HOLD) && bus.out_ready[sel];
        accept      = bus.in_valid && ((state == IDLE) || fire);
        timeout_hit = (TIMEOUT != 0) && (state == HOLD) && !fire && (wait_cnt == WAIT_LAST);
        // A round-robin word accepted in the same cycle a round-robin word fires
        // must start after the channel that just took data, not at the stale pointer.
        rr_base     = (fire && mode_q) ? sel + 3'd1 : rr_ptr;
        load_sel    = bus.mode ? rr_base : bus.in_dest;
        scan_sel    = mode_q ? sel + 3'd1 : sel;
    end

    // in_ready is the only combinational output: it lets a new word in during
    // the cycle the held one leaves, giving one word per cycle.
    assign bus.in_ready  = (state == IDLE) || fire;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.sel       = sel;
    assign bus.drop      = drop;
    assign bus.busy      = (state == HOLD);
    assign bus.sent_cnt  = sent_cnt;
    assign bus.drop_cnt  = drop_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 3'd0;
            rr_ptr    <= 3'd0;
            mode_q    <= 1'b0;
            wait_cnt  <= '0;
            out_valid <= 8'h00;
            out_data  <= '0;
            drop      <= 1'b0;
            sent_cnt  <= 16'h0000;
            drop_cnt  <= 8'h00;
        end else begin
            drop <= 1'b0;

            if (accept) begin
                out_data  <= bus.in_data;
                mode_q    <= bus.mode;
                wait_cnt  <= '0;
                sel       <= load_sel;
                out_valid <= 8'b1 << load_sel;
                state     <= HOLD;
            end else if (fire) begin
                out_valid <= 8'h00;
                state     <= IDLE;
            end else if (timeout_hit) begin
                drop      <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
                out_valid <= 8'h00;
                state     <= IDLE;
            end else if (state == HOLD) begin
                // Not delivered yet: keep waiting, and in round-robin mode move
                // the offer on to the next channel.
                wait_cnt  <= wait_cnt + 1'b1;
                sel       <= scan_sel;
                out_valid <= 8'b1 << scan_sel;
            end

            if (fire) begin
                sent_cnt <= sent_cnt + 16'd1;
                if (mode_q) begin
                    rr_ptr <= sel + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
module tb_demux_dispatch_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    demux_dispatch_if #(.DW(8)) bus ();

    demux_dispatch_ctrl #(.DW(8), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_dest   = 3'd0;
        bus.out_ready = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_valid !== 8'h00 || bus.busy !== 1'b0 || bus.sent_cnt !== 16'h0 ||
            bus.drop_cnt !== 8'h00 || bus.drop !== 1'b0 || bus.sel !== 3'd0 ||
            bus.out_data !== 8'h00 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: out_valid=%h busy=%b sent=%h dropc=%h drop=%b sel=%0d data=%h in_ready=%b, want 00 0 0000 00 0 0 00 1",
                     bus.out_valid, bus.busy, bus.sent_cnt, bus.drop_cnt, bus.drop, bus.sel, bus.out_data, bus.in_ready);
        end
        // Get one word sent, then hold another and reset in the middle of HOLD.
        bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.in_dest = 3'd1; bus.out_ready = 8'h02;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 8'h00; bus.in_valid = 1'b1; bus.in_dest = 3'd6;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 8'h40 || bus.sent_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_pre_hold: busy=%b out_valid=%h sent=%0d, want 1 40 1", bus.busy, bus.out_valid, bus.sent_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 8'h00 || bus.busy !== 1'b0 || bus.sent_cnt !== 16'h0 ||
            bus.drop_cnt !== 8'h00 || bus.drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: out_valid=%h busy=%b sent=%h dropc=%h drop=%b, want all zero",
                     bus.out_valid, bus.busy, bus.sent_cnt, bus.drop_cnt, bus.drop);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.drop !== 1'b0 || bus.drop_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_drop: drop=%b dropc=%h, want 0 00", bus.drop, bus.drop_cnt);
        end
    endtask

    task automatic test_addressed();
        do_reset();
        bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_dest = 3'd5; bus.out_ready = 8'h20;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 8'h20 || bus.out_data !== 8'hA5 || bus.sel !== 3'd5 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL addr_hold: out_valid=%h data=%h sel=%0d busy=%b, want 20 a5 5 1",
                     bus.out_valid, bus.out_data, bus.sel, bus.busy);
        end
        tick();
        checks++;
        if (bus.sent_cnt !== 16'd1 || bus.out_valid !== 8'h00 || bus.busy !== 1'b0 ||
            bus.sel !== 3'd5 || bus.out_data !== 8'hA5) begin
            errors++;
            $display("FAIL addr_fire: sent=%0d out_valid=%h busy=%b sel=%0d data=%h, want 1 00 0 5 a5",
                     bus.sent_cnt, bus.out_valid, bus.busy, bus.sel, bus.out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        do_reset();
        bus.mode = 1'b0; bus.out_ready = 8'hFF; bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 8'h10 + 8'(i * 17);
            bus.in_dest = 3'(i);
            bus.in_data = d;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: in_ready=%b, want 1", i, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== (8'h01 << i) || bus.out_data !== d || bus.sent_cnt !== 16'(i)) begin
                errors++;
                $display("FAIL stream_word[%0d]: out_valid=%h data=%h sent=%0d, want %h %h %0d",
                         i, bus.out_valid, bus.out_data, bus.sent_cnt, 8'h01 << i, d, i);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.sent_cnt !== 16'd8 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_total: sent=%0d busy=%b, want 8 0", bus.sent_cnt, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] starts [3];
        logic [2:0] fires  [3];
        logic [2:0] exp_sel;
        logic       done;
        starts = '{3'd0, 3'd4, 3'd0};
        fires  = '{3'd3, 3'd7, 3'd3};
        do_reset();
        bus.out_ready = 8'h88;
        for (int w = 0; w < 3; w++) begin
            bus.mode = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'(8'h50 + w);
            tick();
            // Mode/dest changes while holding must be ignored.
            bus.in_valid = 1'b0; bus.mode = 1'b0; bus.in_dest = 3'd6;
            exp_sel = starts[w];
            done = 1'b0;
            for (int c = 0; c < 10 && !done; c++) begin
                checks++;
                if (bus.sel !== exp_sel || bus.out_valid !== (8'h01 << exp_sel)) begin
                    errors++;
                    $display("FAIL rr_scan[w%0d c%0d]: sel=%0d out_valid=%h, want %0d %h",
                             w, c, bus.sel, bus.out_valid, exp_sel, 8'h01 << exp_sel);
                end
                if (exp_sel == fires[w]) begin
                    tick();
                    done = 1'b1;
                end else begin
                    tick();
                    exp_sel = exp_sel + 3'd1;
                end
            end
            checks++;
            if (!done || bus.sent_cnt !== 16'(w + 1) || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_fire[w%0d]: done=%b sent=%0d busy=%b, want 1 %0d 0", w, done, bus.sent_cnt, bus.busy, w + 1);
            end
        end
        // rr_ptr must now be 4: the next round-robin word starts at channel 4.
        bus.mode = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.sel !== 3'd4) begin
            errors++;
            $display("FAIL rr_ptr_after: sel=%0d, want 4", bus.sel);
        end
    endtask

    task automatic test_timeout();
        int rise_to_drop;
        do_reset();
        bus.mode = 1'b0; bus.in_dest = 3'd2; bus.in_data = 8'hC3; bus.out_ready = 8'h00; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b1;  // keep offering: must not be accepted while holding
        rise_to_drop = 0;
        while (bus.drop !== 1'b1 && rise_to_drop < 40) begin
            if (bus.in_ready !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL to_in_ready[%0d]: in_ready=%b, want 0", rise_to_drop, bus.in_ready);
            end
            tick();
            rise_to_drop++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (rise_to_drop !== 15 || bus.drop_cnt !== 8'd1 || bus.busy !== 1'b0 ||
            bus.out_valid !== 8'h00 || bus.sent_cnt !== 16'd0) begin
            errors++;
            $display("FAIL timeout_drop: cycles=%0d dropc=%0d busy=%b out_valid=%h sent=%0d, want 15 1 0 00 0",
                     rise_to_drop, bus.drop_cnt, bus.busy, bus.out_valid, bus.sent_cnt);
        end
        tick();
        checks++;
        if (bus.drop !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: drop=%b, want 0", bus.drop);
        end
        // Channel becomes ready in the timeout cycle itself: fire wins.
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.drop !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL timeout_early_drop[%0d]: drop=1, want 0", i);
            end
        end
        bus.out_ready = 8'h04;
        tick();
        checks++;
        if (bus.drop !== 1'b0 || bus.drop_cnt !== 8'd1 || bus.sent_cnt !== 16'd1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire_wins: drop=%b dropc=%0d sent=%0d busy=%b, want 0 1 1 0",
                     bus.drop, bus.drop_cnt, bus.sent_cnt, bus.busy);
        end
    endtask

    task automatic test_saturation_wrap();
        int cyc;
        do_reset();
        bus.mode = 1'b0; bus.in_dest = 3'd2; bus.out_ready = 8'h00;
        for (int n = 1; n <= 300; n++) begin
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            cyc = 0;
            while (bus.drop !== 1'b1 && cyc < 20) begin
                tick();
                cyc++;
            end
            if (bus.drop !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL sat_no_drop[%0d]: drop never pulsed", n);
            end
            if (n == 254 || n == 255 || n == 256) begin
                checks++;
                if (bus.drop_cnt !== ((n < 255) ? 8'(n) : 8'hFF)) begin
                    errors++;
                    $display("FAIL sat_count[%0d]: dropc=%h, want %h", n, bus.drop_cnt, (n < 255) ? 8'(n) : 8'hFF);
                end
            end
        end
        checks++;
        if (bus.drop_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL drop_saturate: dropc=%h, want ff", bus.drop_cnt);
        end
        // Stream fires until sent_cnt reaches 0xFFFF, then one more wraps it.
        do_reset();
        bus.out_ready = 8'hFF; bus.in_dest = 3'd0; bus.in_valid = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        checks++;
        if (bus.sent_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sent_preload: sent=%h, want ffff", bus.sent_cnt);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.sent_cnt !== 16'h0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL sent_wrap: sent=%h busy=%b, want 0000 0", bus.sent_cnt, bus.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_addressed();
        test_back_to_back();
        test_round_robin();
        test_timeout();
        test_saturation_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
